// File: rtl/dram_read_engine.sv
// DRAM-side read responder: turns one {read_addr, read_num} command into a
// sequence of AXI4 INCR read bursts (never crossing a 4 KB page) and streams
// the returned words to the requester as single-cycle buf_we pulses.
`timescale 1ns/1ps
module dram_read_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  kick,
  output logic                  busy,
  input  logic [31:0]           read_num,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] buf_dout,
  output logic                  buf_we,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_R, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             rem_q;
  logic [31:0]             cnt_q;
  logic [8:0]              beats_q;
  logic [8:0]              beats_d;
  logic [31:0]             rem_next;
  logic [ADDR_WIDTH-1:0]   step;
  logic                    beat;
  logic                    unused_addr_lsb;

  // Burst size limited by remaining words, MAX_BURST and words left in the
  // current 4 KB page (page_word is the word offset inside the page).
  function automatic logic [8:0] burst_beats(input logic [9:0]  page_word,
                                             input logic [31:0] rem);
    logic [10:0] page_left;
    logic [8:0]  b;
    page_left = 11'd1024 - {1'b0, page_word};
    b = 9'(MAX_BURST);
    if (page_left < {2'b00, b}) b = page_left[8:0];
    if (rem < {23'd0, b}) b = rem[8:0];
    return b;
  endfunction

  // Word alignment is forced, so the low address bits are never looked at.
  assign unused_addr_lsb = ^read_addr[1:0];

  assign beats_d  = burst_beats(addr_q[11:2], rem_q);
  assign rem_next = rem_q - {23'd0, beats_q};
  assign step     = {{(ADDR_WIDTH-11){1'b0}}, beats_q, 2'b00};
  assign beat     = m_axi_rvalid && m_axi_rready;

  assign busy          = (state_q != S_IDLE);
  assign m_axi_arvalid = (state_q == S_AR);
  assign m_axi_rready  = (state_q == S_R);
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one command, bursts issued strictly one after another.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (kick) state_d = S_CALC;
      S_CALC: state_d = (rem_q == 32'd0) ? S_DONE : S_AR;
      S_AR:   if (m_axi_arready) state_d = S_R;
      S_R:    if (beat && m_axi_rlast) state_d = (rem_next == 32'd0) ? S_DONE : S_CALC;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command tracking, AR channel registers and error accumulation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      beats_q      <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen  <= '0;
      err          <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (kick) begin
          addr_q <= {read_addr[ADDR_WIDTH-1:2], 2'b00};
          rem_q  <= read_num;
          err    <= 1'b0;
        end
        S_CALC: if (rem_q != 32'd0) begin
          beats_q      <= beats_d;
          m_axi_araddr <= addr_q;
          m_axi_arlen  <= beats_d[7:0] - 8'd1;
        end
        S_AR: if (m_axi_arready) cnt_q <= '0;
        S_R: if (beat) begin
          cnt_q <= cnt_q + 32'd1;
          if (m_axi_rresp != 2'b00) err <= 1'b1;
          if (m_axi_rlast) begin
            addr_q <= addr_q + step;
            rem_q  <= rem_next;
            if (cnt_q + 32'd1 != {23'd0, beats_q}) err <= 1'b1;
          end else if (cnt_q >= {23'd0, beats_q}) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage: every accepted R beat appears one cycle later on buf_dout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_we   <= 1'b0;
      buf_dout <= '0;
    end else begin
      buf_we <= beat;
      if (beat) buf_dout <= m_axi_rdata;
    end
  end

endmodule

// File: tb/tb_dram_read_engine.sv
// Bench for dram_read_engine: an AXI read slave backed by an address-hash
// memory, with expected AR commands and words queued when each kick is driven.
`timescale 1ns/1ps
module tb_dram_read_engine;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        kick = 1'b0;
  logic        busy;
  logic [31:0] read_num = '0;
  logic [31:0] read_addr = '0;
  logic [31:0] buf_dout;
  logic        buf_we;
  logic        err;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  dram_read_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(64)) dut (
    .CLK(CLK), .RST_N(RST_N), .kick(kick), .busy(busy),
    .read_num(read_num), .read_addr(read_addr),
    .buf_dout(buf_dout), .buf_we(buf_we), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data[$];
  logic [39:0] exp_ar[$];
  int we_cnt = 0;
  int ar_cnt = 0;
  int arvalid_cnt = 0;
  int stall_cnt = 0;

  // slave configuration and state
  int          ar_hold_cfg = 0;
  int          ar_hold_cnt = 0;
  bit          r_random = 1'b0;
  int          err_beat = -1;
  logic [31:0] r_addr = '0;
  int          r_left = 0;
  int          r_beat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic push_words(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(mem_word(a + 32'(4 * i)));
  endtask

  task automatic kick_cmd(input logic [31:0] a, input logic [31:0] n);
    @(negedge CLK);
    kick = 1'b1; read_addr = a; read_num = n;
    @(negedge CLK);
    kick = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out, output bit last_we);
    int n;
    n = 0;
    last_we = 1'b0;
    while (busy && n < budget) begin
      last_we = buf_we;
      @(negedge CLK);
      n++;
    end
    timed_out = busy;
  endtask

  // AXI read slave: drives decided at each negedge for the following posedge.
  initial begin : slave
    bit          ar_wait_prev;
    logic [31:0] prev_araddr;
    logic [7:0]  prev_arlen;
    logic [39:0] e;
    ar_wait_prev = 1'b0;
    prev_araddr = '0;
    prev_arlen = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        ar_wait_prev = 1'b0;
        continue;
      end
      if (ar_wait_prev) begin
        checks++;
        if (!(m_axi_arvalid === 1'b1 && m_axi_araddr === prev_araddr && m_axi_arlen === prev_arlen)) begin
          errors++;
          $display("FAIL ar_stable: got vld=%b addr=%h len=%0d, required vld=1 addr=%h len=%0d",
                   m_axi_arvalid, m_axi_araddr, m_axi_arlen, prev_araddr, prev_arlen);
        end
      end
      // R channel
      if (r_left > 0) begin
        m_axi_rvalid = r_random ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_rdata  = mem_word(r_addr);
        m_axi_rlast  = (r_left == 1);
        m_axi_rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        r_addr = r_addr + 32'd4; r_left--; r_beat++;
      end
      // AR channel
      if (m_axi_arvalid && ar_hold_cnt > 0) begin
        m_axi_arready = 1'b0; ar_hold_cnt--;
      end else begin
        m_axi_arready = m_axi_arvalid;
      end
      ar_wait_prev = m_axi_arvalid && !m_axi_arready;
      prev_araddr = m_axi_araddr;
      prev_arlen = m_axi_arlen;
      if (ar_wait_prev) stall_cnt++;
      if (m_axi_arvalid && m_axi_arready) begin
        checks++;
        if (exp_ar.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: got addr=%h len=%0d, required no AR", m_axi_araddr, m_axi_arlen);
        end else begin
          e = exp_ar.pop_front();
          if ({m_axi_araddr, m_axi_arlen} !== e) begin
            errors++;
            $display("FAIL ar_cmd: got addr=%h len=%0d, required addr=%h len=%0d",
                     m_axi_araddr, m_axi_arlen, e[39:8], e[7:0]);
          end
        end
        r_addr = m_axi_araddr; r_left = int'(m_axi_arlen) + 1; r_beat = 0;
        ar_cnt++;
        ar_hold_cnt = ar_hold_cfg;
      end
    end
  end

  // Output monitor: every buf_we pops one expected word.
  initial begin : monitor
    logic [31:0] w;
    forever begin
      @(negedge CLK);
      if (m_axi_arvalid) arvalid_cnt++;
      if (buf_we) begin
        we_cnt++;
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL data_unexpected: got %h, required no word", buf_dout);
        end else begin
          w = exp_data.pop_front();
          if (buf_dout !== w) begin
            errors++;
            $display("FAIL data: got %h, required %h", buf_dout, w);
          end
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, buf_we, err, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/we/err/arv/rr=%b, required 00000",
               {busy, buf_we, err, m_axi_arvalid, m_axi_rready});
    end
    checks++;
    if (buf_dout !== 32'd0 || m_axi_araddr !== 32'd0 || m_axi_arlen !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: got dout=%h araddr=%h arlen=%0d, required 0", buf_dout, m_axi_araddr, m_axi_arlen);
    end
    checks++;
    if (m_axi_arsize !== 3'b010 || m_axi_arburst !== 2'b01) begin
      errors++;
      $display("FAIL ar_const: got size=%b burst=%b, required 010/01", m_axi_arsize, m_axi_arburst);
    end
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_burst();
    bit to, lw;
    we_cnt = 0; ar_cnt = 0;
    exp_ar.push_back({32'h0, 8'd63});
    push_words(32'h0, 64);
    kick_cmd(32'h0, 32'd64);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b, required 1", busy); end
    wait_idle(2000, to, lw);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: got busy=1, required 0"); end
    checks++;
    if (lw !== 1'b1) begin errors++; $display("FAIL single_busy_fall: got last_we=%b, required 1", lw); end
    checks++;
    if (we_cnt !== 64) begin errors++; $display("FAIL single_we_count: got %0d, required 64", we_cnt); end
    checks++;
    if (ar_cnt !== 1) begin errors++; $display("FAIL single_ar_count: got %0d, required 1", ar_cnt); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b, required 0", err); end
  endtask

  task automatic test_4k_cross();
    bit to, lw;
    we_cnt = 0; ar_cnt = 0;
    exp_ar.push_back({32'hFC0, 8'd15});
    exp_ar.push_back({32'h1000, 8'd47});
    push_words(32'hFC0, 64);
    kick_cmd(32'hFC0, 32'd64);
    wait_idle(2000, to, lw);
    checks++;
    if (to) begin errors++; $display("FAIL cross_timeout: got busy=1, required 0"); end
    checks++;
    if (we_cnt !== 64 || ar_cnt !== 2) begin
      errors++; $display("FAIL cross_counts: got we=%0d ar=%0d, required 64/2", we_cnt, ar_cnt);
    end
    checks++;
    if (exp_ar.size() != 0 || exp_data.size() != 0) begin
      errors++; $display("FAIL cross_left: got ar=%0d words=%0d pending, required 0", exp_ar.size(), exp_data.size());
    end
  endtask

  task automatic test_long();
    bit to, lw;
    we_cnt = 0; ar_cnt = 0;
    for (int i = 0; i < 25; i++) exp_ar.push_back({32'(i * 256), 8'd63});
    push_words(32'h0, 1600);
    kick_cmd(32'h0, 32'd1600);
    wait_idle(6000, to, lw);
    checks++;
    if (to) begin errors++; $display("FAIL long_timeout: got busy=1, required 0"); end
    checks++;
    if (we_cnt !== 1600 || ar_cnt !== 25) begin
      errors++; $display("FAIL long_counts: got we=%0d ar=%0d, required 1600/25", we_cnt, ar_cnt);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL long_err: got %b, required 0", err); end
  endtask

  task automatic test_zero_and_ignored();
    we_cnt = 0; ar_cnt = 0; arvalid_cnt = 0;
    @(negedge CLK);
    kick = 1'b1; read_addr = 32'h100; read_num = 32'd0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy1: got %b, required 1", busy); end
    read_num = 32'd8;
    @(negedge CLK);
    kick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy2: got %b, required 1", busy); end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_fall: got %b, required 0", busy); end
    repeat (8) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || arvalid_cnt !== 0 || ar_cnt !== 0 || we_cnt !== 0) begin
      errors++;
      $display("FAIL zero_quiet: got busy=%b arvalid_cycles=%0d ar=%0d we=%0d, required 0", busy, arvalid_cnt, ar_cnt, we_cnt);
    end
  endtask

  task automatic test_stall_random();
    bit to, lw;
    we_cnt = 0; ar_cnt = 0; stall_cnt = 0;
    ar_hold_cfg = 10; ar_hold_cnt = 10; r_random = 1'b1;
    exp_ar.push_back({32'h3F80, 8'd31});
    exp_ar.push_back({32'h4000, 8'd63});
    exp_ar.push_back({32'h4100, 8'd3});
    push_words(32'h3F80, 100);
    kick_cmd(32'h3F80, 32'd100);
    wait_idle(4000, to, lw);
    ar_hold_cfg = 0; ar_hold_cnt = 0; r_random = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: got busy=1, required 0"); end
    checks++;
    if (we_cnt !== 100 || ar_cnt !== 3) begin
      errors++; $display("FAIL stall_counts: got we=%0d ar=%0d, required 100/3", we_cnt, ar_cnt);
    end
    checks++;
    if (stall_cnt < 30) begin errors++; $display("FAIL stall_cycles: got %0d, required >=30", stall_cnt); end
  endtask

  task automatic test_rresp_err();
    bit to, lw;
    int n, cyc;
    we_cnt = 0; ar_cnt = 0; err_beat = 4;
    exp_ar.push_back({32'h5000, 8'd15});
    push_words(32'h5000, 16);
    kick_cmd(32'h5000, 32'd16);
    n = 0; cyc = 0;
    while (busy && cyc < 500) begin
      if (buf_we) begin
        n++;
        if (n == 4) begin
          checks++;
          if (err !== 1'b0) begin errors++; $display("FAIL err_before: got %b, required 0", err); end
        end
        if (n == 5) begin
          checks++;
          if (err !== 1'b1) begin errors++; $display("FAIL err_at_beat: got %b, required 1", err); end
        end
      end
      @(negedge CLK);
      cyc++;
    end
    err_beat = -1;
    checks++;
    if (busy || we_cnt !== 16) begin
      errors++; $display("FAIL err_burst: got busy=%b we=%0d, required 0/16", busy, we_cnt);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err); end
    we_cnt = 0;
    exp_ar.push_back({32'h5100, 8'd3});
    push_words(32'h5100, 4);
    kick_cmd(32'h5100, 32'd4);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, required 0", err); end
    wait_idle(500, to, lw);
    checks++;
    if (to || err !== 1'b0 || we_cnt !== 4) begin
      errors++; $display("FAIL err_next_cmd: got busy=%b err=%b we=%0d, required 0/0/4", busy, err, we_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit to, lw;
    int cyc;
    we_cnt = 0; ar_cnt = 0; err_beat = 1;
    exp_ar.push_back({32'h6000, 8'd31});
    push_words(32'h6000, 32);
    kick_cmd(32'h6000, 32'd32);
    cyc = 0;
    while (we_cnt < 6 && cyc < 500) begin @(negedge CLK); cyc++; end
    checks++;
    if (we_cnt < 6 || err !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got we=%0d err=%b busy=%b, required >=6/1/1", we_cnt, err, busy);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({busy, m_axi_arvalid, m_axi_rready, buf_we, err} !== 5'b0) begin
      errors++;
      $display("FAIL rst_async: got busy/arv/rr/we/err=%b, required 00000",
               {busy, m_axi_arvalid, m_axi_rready, buf_we, err});
    end
    checks++;
    if (buf_dout !== 32'd0) begin errors++; $display("FAIL rst_dout: got %h, required 0", buf_dout); end
    exp_data.delete(); exp_ar.delete();
    r_left = 0; err_beat = -1;
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    we_cnt = 0; ar_cnt = 0;
    exp_ar.push_back({32'h7000, 8'd7});
    push_words(32'h7000, 8);
    kick_cmd(32'h7000, 32'd8);
    wait_idle(500, to, lw);
    checks++;
    if (to || we_cnt !== 8 || ar_cnt !== 1 || err !== 1'b0) begin
      errors++; $display("FAIL rst_recover: got busy=%b we=%0d ar=%0d err=%b, required 0/8/1/0", busy, we_cnt, ar_cnt, err);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4k_cross();
    test_long();
    test_zero_and_ignored();
    test_stall_random();
    test_rresp_err();
    test_reset_mid();
    checks++;
    if (exp_data.size() != 0 || exp_ar.size() != 0) begin
      errors++; $display("FAIL final_pending: got words=%0d ar=%0d, required 0", exp_data.size(), exp_ar.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_read_engine.md
Name: dram_read_engine

Overview:
- DRAM-side responder for the frame-copy read request interface (kick/busy/read_num/read_addr in, buf_dout/buf_we out).
- Accepts one read command at a time and splits it into AXI4 INCR read bursts on a memory-controller master port.
- Streams the returned words to the requester in address order as single-cycle buf_we pulses.
- Sits between the image-processing DMA controllers and the MIG AXI slave.

Parameters:
- ADDR_WIDTH, 32, byte-address width of read_addr and m_axi_araddr
- DATA_WIDTH, 32, word width; fixed 32 in this revision, so arsize = 3'b010
- MAX_BURST, 64, maximum beats per AXI burst; legal range 1..256

Ports:
- CLK  in  1  single clock for all logic
- RST_N  in  1  asynchronous active-low reset
- kick  in  1  read command strobe; sampled only while busy=0
- busy  out  1  command in progress
- read_num  in  32  number of 32-bit words to read; latched on accepted kick
- read_addr  in  ADDR_WIDTH  start byte address; latched on accepted kick; bits [1:0] forced to 0
- buf_dout  out  32  read data word
- buf_we  out  1  buf_dout valid, one cycle per word; no backpressure
- err  out  1  sticky error flag; cleared on the next accepted kick
- m_axi_araddr  out  ADDR_WIDTH  AXI AR address
- m_axi_arlen  out  8  AXI AR burst length minus 1
- m_axi_arsize  out  3  constant 3'b010
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  AXI AR valid
- m_axi_arready  in  1  AXI AR ready
- m_axi_rdata  in  32  AXI R data
- m_axi_rresp  in  2  AXI R response
- m_axi_rlast  in  1  AXI R last beat
- m_axi_rvalid  in  1  AXI R valid
- m_axi_rready  out  1  AXI R ready

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; busy, buf_we, err, arvalid and rready are 0; buf_dout, araddr and arlen are 0.
- Reset asserted mid-burst abandons the command immediately. Outstanding R beats are not drained; the system resets the interconnect together with this block.
- States and transitions:
  - IDLE: kick=1 latches addr and rem=read_num, clears err, goes to CALC. busy=1 from the next cycle. kick while busy=1 is ignored.
  - CALC: if rem==0, go to DONE. Otherwise compute beats = min(rem, MAX_BURST, (4096 - addr[11:0])>>2), so no burst crosses a 4 KB boundary. Register araddr=addr and arlen=beats-1, then go to AR.
  - AR: arvalid=1. araddr and arlen are held stable until arready. On the handshake go to R with beat counter cnt=0.
  - R: rready=1. Each beat with rvalid&rready increments cnt. The beat registers into buf_dout, and buf_we pulses the following cycle (one-cycle latency).
    - On the beat with rlast=1: addr += beats*4 (wraps mod 2^ADDR_WIDTH) and rem -= beats.
    - If cnt+1 != beats on that beat, set err.
    - Next state: CALC if the updated rem != 0, else DONE.
    - A beat with rresp != 2'b00 sets err; its data is still forwarded.
    - Beats beyond the expected count without rlast set err and are still forwarded; the burst ends only on rlast.
  - DONE: one cycle, then IDLE. busy falls on entering IDLE, which is the cycle after the final buf_we. For read_num=0, busy is high for exactly 2 cycles (CALC, DONE) and arvalid never rises.
- Ordering and concurrency:
  - Only one AR is outstanding; the next AR is never issued before rlast of the current burst.
  - Words are delivered in ascending address order.
  - The requester must sink buf_we every cycle.
- Widths: rem and cnt are 32 bits; beats is 9 bits; arlen = beats[7:0]-1.

Test Plan:
- kick with read_addr=0x0, read_num=64, arready=1, rvalid always 1 -> one AR (araddr=0x0, arlen=63); exactly 64 buf_we pulses with data matching the memory model; busy=1 from the cycle after kick to the cycle after the last buf_we; err=0.
- read_addr=0xFC0, read_num=64 -> two ARs: (0xFC0, arlen=15) then (0x1000, arlen=47); 64 buf_we total, in order.
- read_num=1600, MAX_BURST=64, read_addr=0x0 -> 25 ARs at 0x0, 0x100, ..., 0x1800, each with arlen=63; 1600 buf_we.
- read_num=0 -> busy high for 2 cycles, no arvalid, no buf_we. A second kick while busy=1 (read_num=8) -> ignored, no AR.
- arready held low 10 cycles and rvalid toggling randomly -> araddr/arlen stable while arvalid=1; buf_we count=read_num; data order preserved.
- rresp=2'b10 on beat 5 of 16 -> err=1 after that beat, all 16 words still delivered; err stays 1 until the next accepted kick clears it. RST_N pulsed low mid-burst -> busy, arvalid, buf_we, err all 0 asynchronously.
